// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   DEFAULT_WIDTH : operand/sum width used when the top is not overridden
//   state_t       : controller state encoding (IDLE / RUN / DONE, 2-bit binary)
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell, the only arithmetic element of the serial adder.
//   x, y : addend bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds a + b + cin LSB-first, one bit per clock,
// through a single full_adder cell.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : begin an addition (accepted in IDLE or DONE)
//   a, b, cin  : operands, captured when start is accepted
//   busy       : high while bits are being processed (RUN)
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : result, held from done until the next accepted start
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  // A start is only honoured when no addition is in flight; DONE accepts it
  // too so back-to-back operations run without an idle bubble.
  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (state == ST_RUN) && (cnt == LAST_BIT);

  full_adder u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: RUN lasts exactly WIDTH edges, DONE lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (cnt == LAST_BIT) next_state = ST_DONE;
      ST_DONE: next_state = start ? ST_RUN : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded directly from the state.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // New sum bit enters at the MSB so that after WIDTH shifts the LSB-first
  // stream lands in natural bit order. Written as shift-then-overwrite so it
  // also elaborates cleanly for WIDTH = 1.
  always_comb begin
    sum_next            = sum_r >> 1;
    sum_next[WIDTH-1]   = fa_s;
  end

  // Datapath: load operands on an accepted start, otherwise step one bit per
  // RUN edge. sum/cout are left alone outside RUN so the result stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
      sum_r <= sum_next;
      if (last_bit) cout_r <= fa_cout;
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit instance exercised with
// directed and randomised additions, and a 1-bit instance checked exhaustively.
// Expected results come from plain integer addition of the operands.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int tests;
  int fails;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for exactly one rising edge (E0); returns
  // 1 time unit after E0.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a8     = av;
    b8     = bv;
    cin8   = cv;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
  endtask

  // Step edges until done is seen (bounded), scrambling the operand inputs so
  // that any leakage into the in-flight addition shows up in the result.
  task automatic waitDone(input int first, output int edges, output int busy_cnt);
    edges    = first;
    busy_cnt = 0;
    while (done8 !== 1'b1 && edges < 40) begin
      if (busy8 === 1'b1) busy_cnt++;
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Compare the done-cycle outputs against the arithmetic reference.
  task automatic checkResult(input string tag, input logic [7:0] av, input logic [7:0] bv,
                             input logic cv, input int edges, input int exp_edges);
    logic [8:0] ref_sum;
    ref_sum = 9'(av) + 9'(bv) + 9'(cv);
    checkOutput({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    checkOutput({tag, "_done"}, 32'(done8), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy8), 32'd0);
    checkOutput({tag, "_sum"}, 32'(sum8), 32'(ref_sum[7:0]));
    checkOutput({tag, "_cout"}, 32'(cout8), 32'(ref_sum[8]));
  endtask

  initial begin
    int edges;
    int busy_cnt;
    int extra;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [7:0] held_sum;
    logic [1:0] ref1;

    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    cin8   = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;

    // Reset values.
    #2;
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_sum", 32'(sum8), 32'd0);
    checkOutput("rst_cout", 32'(cout8), 32'd0);
    checkOutput("rst_done_w1", 32'(done1), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic sum, busy duration, single done pulse, result held afterwards.
    applyStimulus(8'h5A, 8'h3C, 1'b0);
    checkOutput("basic_busy_after_start", 32'(busy8), 32'd1);
    waitDone(0, edges, busy_cnt);
    checkResult("basic", 8'h5A, 8'h3C, 1'b0, edges, 8);
    checkOutput("basic_busy_cycles", 32'(busy_cnt), 32'd8);
    held_sum = sum8;
    @(posedge clk);
    #1;
    checkOutput("basic_done_pulse_ends", 32'(done8), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("basic_sum_held", 32'(sum8), 32'(held_sum));

    // Carry ripple through every bit, and carry-in driven wrap.
    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitDone(0, edges, busy_cnt);
    checkResult("ripple", 8'hFF, 8'h01, 1'b0, edges, 8);
    applyStimulus(8'hFF, 8'h00, 1'b1);
    waitDone(0, edges, busy_cnt);
    checkResult("wrap_cin", 8'hFF, 8'h00, 1'b1, edges, 8);

    // A second start in the 3rd RUN cycle must be ignored entirely.
    applyStimulus(8'h10, 8'h20, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    a8     = 8'hFF;
    b8     = 8'hFF;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    waitDone(3, edges, busy_cnt);
    checkResult("ignored", 8'h10, 8'h20, 1'b0, edges, 8);
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8 === 1'b1) extra++;
    end
    checkOutput("ignored_single_done", 32'(extra), 32'd0);

    // Back-to-back: start held during the DONE cycle.
    applyStimulus(8'h5A, 8'h3C, 1'b0);
    waitDone(0, edges, busy_cnt);
    checkResult("b2b_first", 8'h5A, 8'h3C, 1'b0, edges, 8);
    a8     = 8'h01;
    b8     = 8'h02;
    cin8   = 1'b0;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    checkOutput("b2b_busy_again", 32'(busy8), 32'd1);
    waitDone(1, edges, busy_cnt);
    checkResult("b2b_second", 8'h01, 8'h02, 1'b0, edges, 9);

    // Asynchronous reset in the 4th RUN cycle clears everything at once.
    applyStimulus(8'hFF, 8'h00, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy8), 32'd0);
    checkOutput("midrst_done", 32'(done8), 32'd0);
    checkOutput("midrst_sum", 32'(sum8), 32'd0);
    checkOutput("midrst_cout", 32'(cout8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done8 === 1'b1 || busy8 === 1'b1) extra++;
    end
    checkOutput("midrst_no_done", 32'(extra), 32'd0);

    // Start coincident with the first edge after reset release is accepted.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    a8     = 8'h77;
    b8     = 8'h99;
    cin8   = 1'b1;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    waitDone(0, edges, busy_cnt);
    checkResult("post_rst", 8'h77, 8'h99, 1'b1, edges, 8);

    // Randomised operands against the arithmetic reference.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      applyStimulus(ra, rb, rc);
      waitDone(0, edges, busy_cnt);
      checkResult($sformatf("rand%0d", i), ra, rb, rc, edges, 8);
    end

    // WIDTH = 1: every combination, done two edges after start is presented.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1     = 1'(i >> 2);
      b1     = 1'(i >> 1);
      cin1   = 1'(i);
      start1 = 1'b1;
      ref1   = 2'(a1) + 2'(b1) + 2'(cin1);
      @(posedge clk);
      #1;
      start1 = 1'b0;
      checkOutput($sformatf("w1_busy%0d", i), 32'(busy1), 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("w1_done%0d", i), 32'(done1), 32'd1);
      checkOutput($sformatf("w1_result%0d", i), 32'({cout1, sum1}), 32'(ref1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
